// File: rtl/video_fifo_pkg.sv
// Shared defaults and sizing helpers for the video path FIFO.
package video_fifo_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  // Count needs one extra bit so that a completely full FIFO (2^addr_w) fits.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/video_fifo_ram.sv
// Simple dual-port RAM: one write port and a registered read port that holds its value when idle.
module video_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  // Only the output register is reset; the array keeps whatever it held.
  always_ff @(posedge clk)
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;

  assign rdata = rdata_q;
endmodule

// File: rtl/video_sync_fifo.sv
// Single-clock pixel FIFO with occupancy count, sticky error flags and optional first-word-fall-through.
module video_sync_fifo
  import video_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AF_LVL = (1 << ADDR_W) - 12,
  parameter int AE_LVL = 12,
  parameter bit FWFT   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [DATA_W-1:0]          di,
  input  logic                       re,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty_flag,
  output logic                       full_flag,
  output logic                       afull_flag,
  output logic                       aempty_flag,
  output logic [cnt_w(ADDR_W)-1:0]   count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int CW    = cnt_w(ADDR_W);
  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          wr_acc, rd_acc, fetch, full, empty;

  assign full  = (count_q == CW'(DEPTH));
  // In FWFT mode "not empty" means the head word is already sitting on dout.
  assign empty = FWFT ? !valid_q : (count_q == '0);

  always_comb begin
    wr_acc  = we && !full;
    rd_acc  = re && !empty;
    // FWFT refills the output whenever it is free or being consumed and RAM holds a word.
    fetch   = FWFT ? ((wptr_q != rptr_q) && (!valid_q || rd_acc)) : rd_acc;
    wptr_d  = wptr_q + PW'(wr_acc);
    rptr_d  = rptr_q + PW'(fetch);
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    valid_d = valid_q;
    if (fetch)       valid_d = 1'b1;
    else if (rd_acc) valid_d = 1'b0;
    ovf_d = ovf_q || (we && full);
    udf_d = udf_q || (re && empty);
  end

  always_ff @(posedge clk)
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end

  video_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata (di),
    .re    (fetch),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (dout)
  );

  assign empty_flag  = empty;
  assign full_flag   = full;
  assign afull_flag  = (int'(count_q) >= AF_LVL);
  assign aempty_flag = (int'(count_q) <= AE_LVL);
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
endmodule
